// File: rtl/spi_rx_word_fifo_pkg.sv
// spi_rx_pkg: shared defaults, derived widths and FSM state type for the
// SPI receive word FIFO.
package spi_rx_pkg;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_FIFO_DEPTH  = 16;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = $clog2(DEF_FIFO_DEPTH + 1);
  localparam int DEF_PTR_W       = $clog2(DEF_FIFO_DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Width of a counter that indexes bits 0..dw-1 of a word.
  function automatic int bit_cnt_w(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/spi_rx_word_fifo_if.sv
// Pop-side bus between the SPI word FIFO and its consumer (spi_to_axi).
interface spi_rx_word_fifo_if
  import spi_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_W      = DEF_CNT_W
);
  logic                  i_fifo_en;
  logic                  o_DV;
  logic [DATA_WIDTH-1:0] o_data;
  logic [CNT_W-1:0]      o_fifo_count;

  modport slave (input i_fifo_en, output o_DV, o_data, o_fifo_count);
  modport master(output i_fifo_en, input o_DV, o_data, o_fifo_count);
endinterface

// File: rtl/spi_rx_word_fifo_fifo.sv
// spi_rx_fifo: synchronous word FIFO with registered read port. A pop and a
// push in the same cycle are both accepted even when full.
module spi_rx_fifo
  import spi_rx_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic [CNT_W-1:0]      count_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  // Occupancy follows the accepted push/pop pair.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers, count and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rvalid_q <= pop_ok;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        rdata_q  <= mem_q[rd_ptr_q];
      end
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign count_o  = count_q;

endmodule

// File: rtl/spi_rx_word_fifo.sv
// spi_rx_word_fifo: SPI mode-0 slave receiver oversampled in the clk domain.
// Words are assembled MSB first and buffered in spi_rx_fifo.
// Optional macro SPI_RX_FRAME_ERR_EN enables partial-word (frame error)
// detection on o_frame_err; without it o_frame_err is tied low.
module spi_rx_word_fifo
  import spi_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_spi_sclk,
  input  logic                     i_spi_cs_n,
  input  logic                     i_spi_mosi,
  spi_rx_word_fifo_if.slave        bus,
  output logic                     o_overflow,
  output logic                     o_frame_err
);
  localparam int BCW = bit_cnt_w(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q, vld_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s, cs_n_s, mosi_s, sync_ok, sclk_rise;
  logic                   armed_q;
  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [BCW-1:0]         bit_cnt_q, bit_cnt_d;
  logic                   shift_en, word_done;
  logic                   fifo_full, fifo_empty, pop_acc, drop;
  logic                   overflow_q;

  // Input synchronizers; vld_sync_q marks when the chains hold real pin values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      vld_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_spi_mosi};
      vld_sync_q  <= {vld_sync_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sync_ok   = vld_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;

  // A frame already running at reset release is skipped until CS_N is seen high.
  always_ff @(posedge clk) begin
    if (rst)                    armed_q <= 1'b0;
    else if (sync_ok && cs_n_s) armed_q <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: enter SHIFT on CS_N low, leave on CS_N high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (armed_q && !cs_n_s) state_d = SHIFT;
      SHIFT:   if (cs_n_s)             state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the shift is applied before a same-cycle CS_N rise discards a partial word.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    shift_en  = (state_q == SHIFT) && sclk_rise;
    word_done = shift_en && (bit_cnt_q == LAST_BIT);
    if (state_q == IDLE) bit_cnt_d = '0;
    if (shift_en) begin
      shreg_d   = {shreg_q[DATA_WIDTH-2:0], mosi_s};
      bit_cnt_d = word_done ? '0 : bit_cnt_q + BCW'(1);
    end
    if ((state_q == SHIFT) && cs_n_s) bit_cnt_d = '0;
  end

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

`ifdef SPI_RX_FRAME_ERR_EN
  logic frame_err_q;
  logic frame_err_d;
  assign frame_err_d = (state_q == SHIFT) && cs_n_s && (bit_cnt_q != '0) && !word_done
                       || (state_q == SHIFT) && cs_n_s && shift_en && !word_done;

  // One-cycle pulse when CS_N ends a frame with a partial word.
  always_ff @(posedge clk) begin
    if (rst) frame_err_q <= 1'b0;
    else     frame_err_q <= frame_err_d;
  end
  assign o_frame_err = frame_err_q;
`else
  assign o_frame_err = 1'b0;
`endif

  assign pop_acc = bus.i_fifo_en & ~fifo_empty;
  assign drop    = word_done & fifo_full & ~pop_acc;

  // Sticky flag for a completed word lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (rst)       overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end
  assign o_overflow = overflow_q;

  spi_rx_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH),
    .CNT_W     (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (word_done),
    .wdata_i ({shreg_q[DATA_WIDTH-2:0], mosi_s}),
    .pop_i   (bus.i_fifo_en),
    .rdata_o (bus.o_data),
    .rvalid_o(bus.o_DV),
    .count_o (bus.o_fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule
